// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART responder: register map, status layout,
// oversampling ratio and the state encoding used by both serial FSMs.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DB_LO  = 2'd2;
    localparam logic [1:0] ADDR_DB_HI  = 2'd3;

    localparam int unsigned STAT_TBR  = 0;
    localparam int unsigned STAT_RDA  = 1;
    localparam int unsigned STAT_FERR = 2;
    localparam int unsigned STAT_OVR  = 3;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} spart_state_e;

endpackage

// File: rtl/spart_responder_if.sv
// Processor-side SPART bus control and flag signals; the 8-bit data bus is a separate inout.
interface spart_responder_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);

endinterface

// File: rtl/spart_rx.sv
// 8N1 receiver: rxd synchroniser, start-bit validation at mid-bit, 16x-tick bit sampling.
// done_o / ferr_o are single-cycle registered pulses; data_o is valid with done_o.
module spart_rx
    import spart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    input  logic       tick_i,
    output logic       done_o,
    output logic       ferr_o,
    output logic [7:0] data_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;
    spart_state_e           state_q;
    logic [TICK_W-1:0]      tcnt_q;
    logic [2:0]             bcnt_q;
    logic [7:0]             shift_q;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign data_o = shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            state_q    <= StIdle;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            done_o     <= 1'b0;
            ferr_o     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd_i};
            rxs_prev_q <= rxs;
            done_o     <= 1'b0;
            ferr_o     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rxs_prev_q && !rxs) begin
                        state_q <= StStart;
                        tcnt_q  <= '0;
                    end
                end
                StStart: begin
                    if (tick_i) begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (tcnt_q == MID_TICK) begin
                            // Line back high at mid-bit means a glitch, not a start bit
                            tcnt_q  <= '0;
                            bcnt_q  <= '0;
                            state_q <= rxs ? StIdle : StData;
                        end
                    end
                end
                StData: begin
                    if (tick_i) begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (tcnt_q == LAST_TICK) begin
                            shift_q <= {rxs, shift_q[7:1]};
                            bcnt_q  <= bcnt_q + 1'b1;
                            if (bcnt_q == 3'd7) begin
                                state_q <= StStop;
                            end
                        end
                    end
                end
                StStop: begin
                    if (tick_i) begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if (tcnt_q == LAST_TICK) begin
                            state_q <= StIdle;
                            done_o  <= rxs;
                            ferr_o  <= !rxs;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/spart_responder.sv
// SPART peripheral: bus decode, TX/RX/status/divisor registers, baud generator and 8N1 TX.
// Read data is combinational from registers; read side effects land on the closing edge.
module spart_responder
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET   = 16'd325,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    spart_responder_if.slave  bus,
    inout  wire  [7:0]        databus,
    output logic              txd,
    input  logic              rxd
);

    logic         rd_en, wr_en, rd_data, rd_status, div_wr, tx_wr;
    logic [7:0]   wdata, rdata, status;
    logic [15:0]  div_q, div_d, baud_q, baud_d;
    logic         tick;
    logic         tbr_q, rda_q, ferr_q, ovr_q;
    logic [7:0]   rx_buf_q;
    logic         rx_done, rx_ferr;
    logic [7:0]   rx_data;

    spart_state_e      tx_state_q;
    logic [7:0]        tx_shift_q;
    logic [TICK_W-1:0] tx_tcnt_q;
    logic [2:0]        tx_bcnt_q;

    assign wdata     = databus;
    assign rd_en     = bus.iocs && bus.iorw;
    assign wr_en     = bus.iocs && !bus.iorw;
    assign rd_data   = rd_en && (bus.ioaddr == ADDR_DATA);
    assign rd_status = rd_en && (bus.ioaddr == ADDR_STATUS);
    assign div_wr    = wr_en && ((bus.ioaddr == ADDR_DB_LO) || (bus.ioaddr == ADDR_DB_HI));
    assign tx_wr     = wr_en && (bus.ioaddr == ADDR_DATA) && tbr_q;
    assign tick      = (baud_q == 16'd0);

    always_comb begin
        status            = '0;
        status[STAT_TBR]  = tbr_q;
        status[STAT_RDA]  = rda_q;
        status[STAT_FERR] = ferr_q;
        status[STAT_OVR]  = ovr_q;
        case (bus.ioaddr)
            ADDR_DATA:   rdata = rx_buf_q;
            ADDR_STATUS: rdata = status;
            ADDR_DB_LO:  rdata = div_q[7:0];
            default:     rdata = div_q[15:8];
        endcase
    end

    assign databus = rd_en ? rdata : 8'bz;
    assign bus.rda = rda_q;
    assign bus.tbr = tbr_q;

    always_comb begin
        div_d = div_q;
        if (wr_en && bus.ioaddr == ADDR_DB_LO) div_d[7:0]  = wdata;
        if (wr_en && bus.ioaddr == ADDR_DB_HI) div_d[15:8] = wdata;
        // A divisor write restarts the baud period with the complete new value
        if (div_wr)    baud_d = div_d;
        else if (tick) baud_d = div_q;
        else           baud_d = baud_q - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= DIV_RESET;
            baud_q   <= DIV_RESET;
            rx_buf_q <= '0;
            rda_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            div_q  <= div_d;
            baud_q <= baud_d;
            if (rx_done) begin
                rx_buf_q <= rx_data;
                rda_q    <= 1'b1;
            end else if (rd_data) begin
                rda_q <= 1'b0;
            end
            // Completion racing a data read counts as consumed, not overrun
            if (rx_done && rda_q && !rd_data) ovr_q <= 1'b1;
            else if (rd_status)                ovr_q <= 1'b0;
            if (rx_ferr)        ferr_q <= 1'b1;
            else if (rd_status) ferr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_shift_q <= '0;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            txd        <= 1'b1;
            tbr_q      <= 1'b1;
        end else begin
            unique case (tx_state_q)
                StIdle: begin
                    if (tx_wr) begin
                        tx_shift_q <= wdata;
                        tx_tcnt_q  <= '0;
                        tbr_q      <= 1'b0;
                        txd        <= 1'b0;
                        tx_state_q <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        if (tx_tcnt_q == LAST_TICK) begin
                            tx_bcnt_q  <= '0;
                            txd        <= tx_shift_q[0];
                            tx_state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        if (tx_tcnt_q == LAST_TICK) begin
                            tx_bcnt_q <= tx_bcnt_q + 1'b1;
                            if (tx_bcnt_q == 3'd7) begin
                                txd        <= 1'b1;
                                tx_state_q <= StStop;
                            end else begin
                                tx_shift_q <= tx_shift_q >> 1;
                                txd        <= tx_shift_q[1];
                            end
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        if (tx_tcnt_q == LAST_TICK) begin
                            tbr_q      <= 1'b1;
                            tx_state_q <= StIdle;
                        end
                    end
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    spart_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxd_i  (rxd),
        .tick_i (tick),
        .done_o (rx_done),
        .ferr_o (rx_ferr),
        .data_o (rx_data)
    );

endmodule

// File: tb/tb_spart_responder.sv
// Directed self-checking bench for spart_responder: register map, TX framing, RX, overrun,
// framing error, glitch rejection, mid-frame reset and txd->rxd loopback.
module tb_spart_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spart_responder_if bus ();

    logic       tb_drv;
    logic [7:0] tb_wdata;
    wire  [7:0] databus;
    assign databus = tb_drv ? tb_wdata : 8'bz;

    logic txd;
    logic rxd_drv;
    logic loop_en;
    wire  rxd;
    assign rxd = loop_en ? txd : rxd_drv;

    int checks = 0;
    int errors = 0;
    logic [7:0] rd;

    spart_responder #(
        .DIV_RESET   (16'd325),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    // All tasks start and end 1ns after a rising edge.
    task automatic tick_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
        tb_drv = 1'b1; tb_wdata = d;
        tick_clk(1);
        bus.iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
        #1;
        d = databus;
        tick_clk(1);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
    endtask

    // 64 clocks per bit matches divisor 3.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        tick_clk(64);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            tick_clk(64);
        end
        rxd_drv = stop;
        tick_clk(64);
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick_clk(3);
        rst = 1'b0;
        checks++;
        if (txd !== 1'b1 || bus.tbr !== 1'b1 || bus.rda !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins: txd=%b tbr=%b rda=%b, required 1 1 0", txd, bus.tbr, bus.rda);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL reset_status: got %h required 01", rd);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 8'h45) begin
            errors++; $display("FAIL reset_div_lo: got %h required 45", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL reset_div_hi: got %h required 01", rd);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++; $display("FAIL reset_rxbuf: got %h required 00", rd);
        end
    endtask

    task automatic test_divisor;
        bus_write(2'd2, 8'h03);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 8'h03) begin
            errors++; $display("FAIL div_lo_wr: got %h required 03", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 8'h00) begin
            errors++; $display("FAIL div_hi_wr: got %h required 00", rd);
        end
    endtask

    task automatic test_tx;
        logic [9:0]  exp_bits;
        int unsigned t0;
        int          lows;
        int          waited;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        bus_write(2'd0, 8'hA5);
        t0 = cyc;
        checks++;
        if (bus.tbr !== 1'b0) begin
            errors++; $display("FAIL tx_tbr_busy: got %b required 0", bus.tbr);
        end
        for (int k = 0; k < 10; k++) begin
            wait_until(t0 + 64 * k + 32);
            checks++;
            if (txd !== exp_bits[k]) begin
                errors++; $display("FAIL tx_bit%0d: got %b required %b", k, txd, exp_bits[k]);
            end
            if (k == 3) bus_write(2'd0, 8'h0F);
        end
        waited = 0;
        while (bus.tbr !== 1'b1 && waited < 100) begin
            tick_clk(1);
            waited++;
        end
        checks++;
        if (bus.tbr !== 1'b1) begin
            errors++; $display("FAIL tx_tbr_done: got %b required 1 within 100 clocks", bus.tbr);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (txd !== 1'b1) lows++;
            tick_clk(1);
        end
        checks++;
        if (lows != 0) begin
            errors++; $display("FAIL tx_ignored_write: txd low for %0d clocks, required 0", lows);
        end
    endtask

    task automatic test_rx;
        send_frame(8'h3C, 1'b1);
        checks++;
        if (bus.rda !== 1'b1) begin
            errors++; $display("FAIL rx_rda_set: got %b required 1", bus.rda);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 8'h3C) begin
            errors++; $display("FAIL rx_data: got %h required 3c", rd);
        end
        checks++;
        if (bus.rda !== 1'b0) begin
            errors++; $display("FAIL rx_rda_clr: got %b required 0", bus.rda);
        end
    endtask

    // Status values include tbr=1 since the transmitter is idle here.
    task automatic test_overrun;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h0B) begin
            errors++; $display("FAIL ovr_status: got %h required 0b", rd);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h03) begin
            errors++; $display("FAIL ovr_cleared: got %h required 03", rd);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 8'h22) begin
            errors++; $display("FAIL ovr_data: got %h required 22", rd);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL ovr_final_status: got %h required 01", rd);
        end
    endtask

    task automatic test_frame_err;
        send_frame(8'h55, 1'b0);
        checks++;
        if (bus.rda !== 1'b0) begin
            errors++; $display("FAIL ferr_rda: got %b required 0", bus.rda);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h05) begin
            errors++; $display("FAIL ferr_status: got %h required 05", rd);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL ferr_cleared: got %h required 01", rd);
        end
    endtask

    task automatic test_glitch;
        rxd_drv = 1'b0;
        tick_clk(12);
        rxd_drv = 1'b1;
        tick_clk(100);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL glitch_status: got %h required 01", rd);
        end
        send_frame(8'h5A, 1'b1);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 8'h5A) begin
            errors++; $display("FAIL glitch_next_frame: got %h required 5a", rd);
        end
    endtask

    task automatic test_reset_mid_tx;
        bus_write(2'd0, 8'hFF);
        tick_clk(30);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL rst_pre_start_bit: got %b required 0", txd);
        end
        rst = 1'b1;
        tick_clk(1);
        rst = 1'b0;
        checks++;
        if (txd !== 1'b1 || bus.tbr !== 1'b1) begin
            errors++; $display("FAIL rst_mid_tx: txd=%b tbr=%b required 1 1", txd, bus.tbr);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 8'h45) begin
            errors++; $display("FAIL rst_div_lo: got %h required 45", rd);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 8'h01) begin
            errors++; $display("FAIL rst_div_hi: got %h required 01", rd);
        end
    endtask

    task automatic test_loopback;
        logic [7:0] pats [2];
        int         waited;
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        bus_write(2'd2, 8'h03);
        bus_write(2'd3, 8'h00);
        loop_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            waited = 0;
            while (bus.tbr !== 1'b1 && waited < 200) begin
                tick_clk(1);
                waited++;
            end
            bus_write(2'd0, pats[p]);
            waited = 0;
            while (bus.rda !== 1'b1 && waited < 1000) begin
                tick_clk(1);
                waited++;
            end
            bus_read(2'd0, rd);
            checks++;
            if (rd !== pats[p]) begin
                errors++; $display("FAIL loopback_%0d: got %h required %h", p, rd, pats[p]);
            end
        end
        loop_en = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'd0;
        tb_drv     = 1'b0;
        tb_wdata   = 8'h00;
        rxd_drv    = 1'b1;
        loop_en    = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_divisor;
        test_tx;
        test_rx;
        test_overrun;
        test_frame_err;
        test_glitch;
        test_reset_mid_tx;
        test_loopback;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
